// File: rtl/nes_pad_scheduler_if.sv
// ============================================================================
// Module   : nes_pad_scheduler_if
// Brief    : APB3 slave-side bus bundle for the NES pad scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface nes_pad_scheduler_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

`default_nettype wire

// File: rtl/nes_pad_scheduler.sv
// ============================================================================
// Module   : nes_pad_scheduler
// Brief    : APB3 poller for two NES pads on a shared latch/clock pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nes_pad_scheduler #(
    parameter int HALF_DIV = 600,
    parameter int PERIOD_W = 24
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    nes_pad_scheduler_if.slave   apb,
    output logic                 pad_latch,
    output logic                 pad_clock,
    input  logic                 pad_data0,
    input  logic                 pad_data1,
    output logic                 irq
);

    localparam int              c_DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(HALF_DIV - 1);
    localparam logic [7:0]      c_A_CTRL   = 8'h00;
    localparam logic [7:0]      c_A_PERIOD = 8'h04;
    localparam logic [7:0]      c_A_PAD0   = 8'h08;
    localparam logic [7:0]      c_A_PAD1   = 8'h0C;
    localparam logic [7:0]      c_A_PRESS  = 8'h10;
    localparam logic [7:0]      c_A_STATUS = 8'h14;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SAMPLE = 3'd2,
        S_CLK_HI = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           shift0_q, shift0_d, shift1_q, shift1_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [PERIOD_W-1:0]  period_q, period_d, per_cnt_q, per_cnt_d;
    logic [7:0]           pad0_q, pad0_d, pad1_q, pad1_d;
    logic [15:0]          press_q, press_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic                 pend_q, pend_d, pend_trig_q, pend_trig_d;
    logic                 latch_q, latch_d, clock_q, clock_d, irq_q, irq_d;

    logic [15:0]          w_press_set, w_press_clr;
    logic                 w_ovr_set;
    logic [31:0]          w_rdata;

    wire w_wr        = apb.PSEL & apb.PENABLE & apb.PWRITE;
    wire w_wr_ctrl   = w_wr && (apb.PADDR == c_A_CTRL);
    wire w_wr_period = w_wr && (apb.PADDR == c_A_PERIOD);
    wire w_wr_press  = w_wr && (apb.PADDR == c_A_PRESS);
    wire w_wr_status = w_wr && (apb.PADDR == c_A_STATUS);
    wire w_idle      = (state_q == S_IDLE);
    wire w_tick      = (div_q == c_DIV_LAST);
    wire w_trig      = w_wr_ctrl & apb.PWDATA[3];
    wire w_per_wrap  = (period_q == '0) || (per_cnt_q == period_q - PERIOD_W'(1));
    // PERIOD=0 degenerates into "poll whenever idle", never a busy-time request.
    wire w_per_req   = ctrl_q[0] && ((period_q == '0) ? w_idle : w_per_wrap);
    wire w_req       = w_per_req | w_trig;
    wire w_unused_ok = &{1'b0, apb.PWDATA};

    always_comb begin
        state_d     = state_q;
        div_d       = (w_idle || w_tick) ? '0 : div_q + c_DIV_W'(1);
        bitcnt_d    = bitcnt_q;
        shift0_d    = shift0_q;
        shift1_d    = shift1_q;
        ctrl_d      = w_wr_ctrl ? apb.PWDATA[2:0] : ctrl_q;
        period_d    = w_wr_period ? apb.PWDATA[PERIOD_W-1:0] : period_q;
        per_cnt_d   = (!ctrl_q[0] || w_wr_period || w_per_wrap) ? '0 : per_cnt_q + PERIOD_W'(1);
        pad0_d      = pad0_q;
        pad1_d      = pad1_q;
        fcnt_d      = fcnt_q;
        pend_d      = pend_q;
        pend_trig_d = pend_trig_q;
        w_press_set = '0;
        w_press_clr = w_wr_press ? apb.PWDATA[15:0] : '0;
        w_ovr_set   = 1'b0;

        if (w_idle) begin
            if (w_req || pend_q) begin
                state_d     = S_LATCH;
                bitcnt_d    = '0;
                pend_d      = 1'b0;
                pend_trig_d = 1'b0;
            end
        end else if (w_req) begin
            if (pend_q) w_ovr_set = 1'b1;
            else        pend_d    = 1'b1;
            pend_trig_d = pend_trig_q | w_trig;
        end

        // Dropping EN discards a queued periodic poll but never a software trigger.
        if (w_wr_ctrl && !apb.PWDATA[0] && !pend_trig_d) pend_d = 1'b0;

        case (state_q)
            S_LATCH:  if (w_tick) state_d = S_SAMPLE;
            S_SAMPLE: if (w_tick) begin
                shift0_d = {shift0_q[6:0], ~pad_data0};
                shift1_d = {shift1_q[6:0], ~pad_data1};
                bitcnt_d = bitcnt_q + 4'd1;
                state_d  = (bitcnt_q == 4'd7) ? S_DONE : S_CLK_HI;
            end
            S_CLK_HI: if (w_tick) state_d = S_SAMPLE;
            S_DONE: begin
                w_press_set[7:0] = shift0_q & ~pad0_q;
                pad0_d           = shift0_q;
                if (ctrl_q[1]) begin
                    w_press_set[15:8] = shift1_q & ~pad1_q;
                    pad1_d            = shift1_q;
                end else begin
                    pad1_d = '0;
                end
                fcnt_d  = fcnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        press_d = (press_q & ~w_press_clr) | w_press_set;
        ovr_d   = (ovr_q & ~(w_wr_status & apb.PWDATA[1])) | w_ovr_set;
        latch_d = (state_d == S_LATCH);
        clock_d = (state_d == S_CLK_HI);
        irq_d   = ctrl_q[2] & (|press_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bitcnt_q    <= '0;
            shift0_q    <= '0;
            shift1_q    <= '0;
            ctrl_q      <= '0;
            period_q    <= '0;
            per_cnt_q   <= '0;
            pad0_q      <= '0;
            pad1_q      <= '0;
            press_q     <= '0;
            ovr_q       <= 1'b0;
            fcnt_q      <= '0;
            pend_q      <= 1'b0;
            pend_trig_q <= 1'b0;
            latch_q     <= 1'b0;
            clock_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bitcnt_q    <= bitcnt_d;
            shift0_q    <= shift0_d;
            shift1_q    <= shift1_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            per_cnt_q   <= per_cnt_d;
            pad0_q      <= pad0_d;
            pad1_q      <= pad1_d;
            press_q     <= press_d;
            ovr_q       <= ovr_d;
            fcnt_q      <= fcnt_d;
            pend_q      <= pend_d;
            pend_trig_q <= pend_trig_d;
            latch_q     <= latch_d;
            clock_q     <= clock_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (apb.PADDR)
                c_A_CTRL:   w_rdata[2:0]          = ctrl_q;
                c_A_PERIOD: w_rdata[PERIOD_W-1:0] = period_q;
                c_A_PAD0:   w_rdata[7:0]          = pad0_q;
                c_A_PAD1:   w_rdata[7:0]          = pad1_q;
                c_A_PRESS:  w_rdata[15:0]         = press_q;
                c_A_STATUS: w_rdata[15:0]         = {fcnt_q, 6'b0, ovr_q, !w_idle};
                default:    w_rdata               = '0;
            endcase
        end
    end

    assign apb.PRDATA  = w_rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign pad_latch   = latch_q;
    assign pad_clock   = clock_q;
    assign irq         = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_scheduler.sv
// ============================================================================
// Module   : tb_nes_pad_scheduler
// Brief    : Scoreboard bench for nes_pad_scheduler with a two-pad shift model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nes_pad_scheduler;
    localparam int HD = 4;

    logic clk = 1'b0;
    logic rst;
    logic pad_latch, pad_clock, pad_data0, pad_data1, irq;
    logic [7:0] pat0, pat1;

    always #5 clk = ~clk;

    nes_pad_scheduler_if apb_if();

    nes_pad_scheduler #(.HALF_DIV(HD), .PERIOD_W(24)) dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .apb       (apb_if),
        .pad_latch (pad_latch),
        .pad_clock (pad_clock),
        .pad_data0 (pad_data0),
        .pad_data1 (pad_data1),
        .irq       (irq)
    );

    // Pad model: latch reloads, each rising pad_clock advances to the next button.
    int   pidx;
    logic pclk_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pidx      <= 0;
            pclk_prev <= 1'b0;
        end else begin
            pclk_prev <= pad_clock;
            if (pad_latch)                                 pidx <= 0;
            else if (pad_clock && !pclk_prev && pidx < 8)  pidx <= pidx + 1;
        end
    end
    assign pad_data0 = (pidx < 8) ? ~pat0[7 - pidx] : 1'b0;
    assign pad_data1 = (pidx < 8) ? ~pat1[7 - pidx] : 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;
    exp_t sb_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (apb_if.PSEL && apb_if.PENABLE && !apb_if.PWRITE) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", apb_if.PRDATA, 32'hxxxx_xxxx);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    chk(x.name, apb_if.PRDATA & x.mask, x.exp & x.mask);
                end
            end
        end
    end

    // Pin-level frame observer.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int latch_start, latch_len, clk_pulses, clk_len, clk_len_bad, last_fall, last_interval;
    int frames_since_rst = 0;
    logic lat_prev = 1'b0, clk_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) frames_since_rst = 0;
            if (pad_latch && !lat_prev) begin
                last_interval = cyc - latch_start;
                latch_start   = cyc;
                frames_since_rst++;
                latch_len = 0; clk_pulses = 0; clk_len_bad = 0; last_fall = 0;
            end
            if (pad_latch) latch_len++;
            if (pad_clock && !clk_prev) begin
                clk_pulses++;
                clk_len = 1;
            end else if (pad_clock) begin
                clk_len++;
            end
            if (!pad_clock && clk_prev) begin
                if (clk_len != HD) clk_len_bad++;
                last_fall = cyc - latch_start;
            end
            lat_prev = pad_latch;
            clk_prev = pad_clock;
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb_if.PSEL = 1'b1; apb_if.PWRITE = 1'b1; apb_if.PADDR = a; apb_if.PWDATA = d;
        apb_if.PENABLE = 1'b0;
        @(posedge clk); #1 apb_if.PENABLE = 1'b1;
        @(posedge clk); #1 apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] e, input logic [31:0] m,
                            input string nm);
        exp_t x;
        x.name = nm; x.exp = e; x.mask = m;
        sb_q.push_back(x);
        apb_if.PSEL = 1'b1; apb_if.PWRITE = 1'b0; apb_if.PADDR = a; apb_if.PENABLE = 1'b0;
        @(posedge clk); #1 apb_if.PENABLE = 1'b1;
        @(posedge clk); #1 apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int lim, input string nm);
        int k = 0;
        while (frames_since_rst < target && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= lim) chk(nm, 32'(frames_since_rst), 32'(target));
    endtask

    task automatic wait_latch(input string nm);
        int k = 0;
        while (!pad_latch && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk(nm, 32'(pad_latch), 32'd1);
    endtask

    localparam logic [7:0] A_CTRL = 8'h00, A_PER = 8'h04, A_PAD0 = 8'h08, A_PAD1 = 8'h0C,
                           A_PRESS = 8'h10, A_STAT = 8'h14;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    initial begin
        int f;
        rst = 1'b1;
        pat0 = 8'h00; pat1 = 8'h00;
        apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0;
        apb_if.PADDR = '0; apb_if.PWDATA = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and unmapped address.
        apb_read(A_CTRL, 0, ALL, "rst_ctrl");
        apb_read(A_STAT, 0, ALL, "rst_status");
        apb_read(A_PRESS, 0, ALL, "rst_press");
        chk("rst_irq", 32'(irq), 0);
        apb_write(8'h18, ALL);
        apb_read(8'h18, 0, ALL, "unmapped_rd");

        // Scenario 1: single triggered frame, A and Right pressed on pad 0.
        pat0 = 8'h81;
        apb_write(A_CTRL, 32'h8);
        wait_latch("t1_latch_timeout");
        wait_cycles(63);
        apb_read(A_STAT, 32'h0001, ALL, "t1_status_in_done");
        apb_read(A_STAT, 32'h0100, ALL, "t1_status_after");
        apb_read(A_PAD0, 32'h81, ALL, "t1_pad0");
        apb_read(A_PAD1, 32'h00, ALL, "t1_pad1");
        apb_read(A_PRESS, 32'h0081, ALL, "t1_press");
        chk("t1_latch_len", 32'(latch_len), HD);
        chk("t1_clk_pulses", 32'(clk_pulses), 7);
        chk("t1_clk_len_bad", 32'(clk_len_bad), 0);
        chk("t1_last_clk_fall", 32'(last_fall), 60);
        apb_read(A_CTRL, 32'h0, ALL, "t1_trig_selfclr");

        // Scenario 2: irq enable, W1C, repeat frame with no new edges.
        apb_write(A_CTRL, 32'h4);
        wait_cycles(1);
        chk("t2_irq_set", 32'(irq), 1);
        apb_write(A_PRESS, 32'h81);
        chk("t2_irq_lag", 32'(irq), 1);
        wait_cycles(1);
        chk("t2_irq_drop", 32'(irq), 0);
        apb_write(A_CTRL, 32'hC);
        wait_cycles(80);
        apb_read(A_PRESS, 32'h0, ALL, "t2_press_noedge");
        apb_read(A_STAT, 32'h0200, ALL, "t2_status");
        chk("t2_irq_idle", 32'(irq), 0);

        // Scenario 3: periodic polling with pad 1 enabled.
        pat1 = 8'h3C;
        apb_write(A_PER, 32'd100);
        apb_write(A_CTRL, 32'h3);
        f = frames_since_rst;
        wait_frames(f + 3, 500, "t3_frames_timeout");
        chk("t3_interval", 32'(last_interval), 100);
        wait_cycles(70);
        apb_read(A_PAD1, 32'h3C, ALL, "t3_pad1");
        apb_read(A_PAD0, 32'h81, ALL, "t3_pad0");
        apb_read(A_PRESS, 32'h3C00, ALL, "t3_press");
        apb_write(A_PRESS, 32'hFFFF);
        wait_cycles(110);
        apb_read(A_PRESS, 32'h0, ALL, "t3_press_once");
        apb_write(A_CTRL, 32'h0);
        wait_cycles(80);

        // Scenario 6: asynchronous reset while the pad clock is high.
        apb_write(A_PER, 32'h1234);
        apb_write(A_CTRL, 32'hE);
        begin
            int k = 0;
            while (!pad_clock && k < 100) begin @(posedge clk); #1; k++; end
            if (k >= 100) chk("t6_clk_timeout", 32'(pad_clock), 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_clock", 32'(pad_clock), 0);
        chk("t6_rst_latch", 32'(pad_latch), 0);
        apb_if.PSEL = 1'b1; apb_if.PWRITE = 1'b0; apb_if.PADDR = A_STAT;
        #1;
        chk("t6_rst_busy", apb_if.PRDATA, 0);
        apb_if.PSEL = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        apb_read(A_CTRL, 0, ALL, "t6_ctrl");
        apb_read(A_PER, 0, ALL, "t6_period");
        apb_read(A_PAD0, 0, ALL, "t6_pad0");
        apb_read(A_PAD1, 0, ALL, "t6_pad1");
        apb_read(A_PRESS, 0, ALL, "t6_press");
        apb_read(A_STAT, 0, ALL, "t6_status");

        // Scenario 5: PRESS W1C landing in the DONE cycle.
        apb_write(A_CTRL, 32'h8);
        wait_latch("t5_latch_timeout");
        wait_cycles(63);
        apb_write(A_PRESS, 32'h80);
        apb_read(A_PRESS, 32'h0081, ALL, "t5_press_set_wins");
        apb_read(A_STAT, 32'h0100, ALL, "t5_status");

        // Scenario 4: period shorter than a frame, overrun and counter wrap.
        apb_write(A_PER, 32'd10);
        apb_write(A_CTRL, 32'h1);
        wait_frames(4, 1000, "t4_start_timeout");
        chk("t4_interval", 32'(last_interval), 66);
        apb_read(A_STAT, 32'h2, 32'h2, "t4_overrun");
        wait_frames(258, 20000, "t4_wrap_timeout");
        apb_write(A_CTRL, 32'h0);
        wait_cycles(100);
        f = frames_since_rst;
        chk("t4_wrapped", 32'(f > 256), 1);
        apb_read(A_STAT, ((f % 256) << 8) | 2, ALL, "t4_status_wrap");
        apb_write(A_STAT, 32'h2);
        apb_read(A_STAT, (f % 256) << 8, ALL, "t4_overrun_w1c");

        wait_cycles(2);
        if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
